// File: rtl/operand_sequencer_if.sv
// rtl/operand_sequencer_if.sv - keypad, arithmetic-unit and datapath-strobe bundle for operand_sequencer
interface operand_sequencer_if #(
    parameter int N_OPERANDS = 2,
    parameter int IDX_W      = 1
);
    logic                  key_valid;
    logic [3:0]            key_code;
    logic                  calc_done;
    logic [IDX_W-1:0]      op_idx;
    logic                  load_digit;
    logic [N_OPERANDS-1:0] load_op;
    logic                  calc_start;
    logic                  load_m;
    logic                  busy;
    logic                  err;

    modport master (
        output key_valid, key_code, calc_done,
        input  op_idx, load_digit, load_op, calc_start, load_m, busy, err
    );

    modport slave (
        input  key_valid, key_code, calc_done,
        output op_idx, load_digit, load_op, calc_start, load_m, busy, err
    );
endinterface

// File: rtl/operand_sequencer.sv
// rtl/operand_sequencer.sv - keypad operand collection FSM with arithmetic-unit start/done handshake
// Optional calc_done watchdog and ERR state: define OPERAND_SEQ_WATCHDOG_EN.
module operand_sequencer #(
    parameter int N_OPERANDS = 2,
    parameter int DIGITS     = 4,
    parameter int TIMEOUT    = 255,
    parameter int IDX_W      = (N_OPERANDS > 1) ? $clog2(N_OPERANDS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    operand_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(DIGITS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_CALC, S_WAIT, S_RESULT, S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      op_idx_q, op_idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  load_digit_q, load_digit_d;
    logic [N_OPERANDS-1:0] load_op_q, load_op_d;
    logic                  calc_start_q, calc_start_d;
    logic                  load_m_q, load_m_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;

    logic is_digit, is_enter, is_clear, do_clear, last_op, cnt_full;

    assign is_digit = bus.key_valid && (bus.key_code <= 4'd9);
    assign is_enter = bus.key_valid && (bus.key_code == 4'hE);
    assign is_clear = bus.key_valid && (bus.key_code == 4'hF);
    // RESULT always completes so the result register load is never lost
    assign do_clear = is_clear && (state_q != S_RESULT);
    assign last_op  = (op_idx_q == IDX_W'(N_OPERANDS - 1));
    assign cnt_full = (cnt_q == CNT_W'(DIGITS));

`ifdef OPERAND_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_expired;

    assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));
    assign wd_d = (state_q == S_WAIT && state_d == S_WAIT) ? wd_q + WD_W'(1) : '0;

    always_ff @(posedge clk) begin
        if (rst) wd_q <= '0;
        else     wd_q <= wd_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_idx_q     <= '0;
            cnt_q        <= '0;
            load_digit_q <= 1'b0;
            load_op_q    <= '0;
            calc_start_q <= 1'b0;
            load_m_q     <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_idx_q     <= op_idx_d;
            cnt_q        <= cnt_d;
            load_digit_q <= load_digit_d;
            load_op_q    <= load_op_d;
            calc_start_q <= calc_start_d;
            load_m_q     <= load_m_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_idx_d = op_idx_q;
        cnt_d    = cnt_q;
        if (do_clear) begin
            state_d  = S_IDLE;
            op_idx_d = '0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: if (is_digit) begin
                    state_d  = S_COLLECT;
                    op_idx_d = '0;
                    cnt_d    = CNT_W'(1);
                end
                S_COLLECT: begin
                    if (is_digit && !cnt_full) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (is_enter && cnt_q != '0) begin
                        cnt_d = '0;
                        if (last_op) state_d  = S_CALC;
                        else         op_idx_d = op_idx_q + IDX_W'(1);
                    end
                end
                S_CALC: state_d = S_WAIT;
                S_WAIT: begin
                    if (bus.calc_done) state_d = S_RESULT;
`ifdef OPERAND_SEQ_WATCHDOG_EN
                    else if (wd_expired) state_d = S_ERR;
`endif
                end
                S_RESULT: begin
                    state_d  = S_IDLE;
                    op_idx_d = '0;
                end
`ifdef OPERAND_SEQ_WATCHDOG_EN
                S_ERR: state_d = S_ERR;
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        load_digit_d = 1'b0;
        load_op_d    = '0;
        calc_start_d = 1'b0;
        load_m_d     = 1'b0;
        busy_d       = (state_d != S_IDLE);
`ifdef OPERAND_SEQ_WATCHDOG_EN
        err_d        = (state_d == S_ERR);
`else
        err_d        = 1'b0;
`endif
        if (!do_clear) begin
            case (state_q)
                S_IDLE: load_digit_d = is_digit;
                S_COLLECT: begin
                    load_digit_d = is_digit && !cnt_full;
                    if (is_enter && cnt_q != '0)
                        load_op_d = N_OPERANDS'(1) << op_idx_q;
                end
                S_CALC:  calc_start_d = 1'b1;
                S_WAIT:  load_m_d     = bus.calc_done;
                default: ;
            endcase
        end
    end

    assign bus.op_idx     = op_idx_q;
    assign bus.load_digit = load_digit_q;
    assign bus.load_op    = load_op_q;
    assign bus.calc_start = calc_start_q;
    assign bus.load_m     = load_m_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_operand_sequencer.sv
// tb/tb_operand_sequencer.sv - per-cycle vector table with pulse scoreboard for operand_sequencer
module tb_operand_sequencer;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    operand_sequencer_if #(.N_OPERANDS(2), .IDX_W(1)) bus0();
    operand_sequencer_if #(.N_OPERANDS(3), .IDX_W(2)) bus1();

    operand_sequencer #(.N_OPERANDS(2), .DIGITS(4), .TIMEOUT(TIMEOUT), .IDX_W(1))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    operand_sequencer #(.N_OPERANDS(3), .DIGITS(1), .TIMEOUT(TIMEOUT), .IDX_W(2))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        int kv, kc, cd;
        int ld, lo, cs, lm;
        int busy, idx, err;
    } vec_t;

    typedef struct {
        int cyc;
        int code;
    } ev_t;

    vec_t tbl[$];
    ev_t  exp_q[$];

    function automatic vec_t mk(input int kv, input int kc, input int cd, input int ld, input int lo,
                                input int cs, input int lm, input int busy, input int idx, input int err);
        vec_t v;
        v.kv = kv; v.kc = kc; v.cd = cd; v.ld = ld; v.lo = lo;
        v.cs = cs; v.lm = lm; v.busy = busy; v.idx = idx; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input int row, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    // pulse codes: 16+op_idx digit, 32+mask load_op, 48 calc_start, 64 load_m
    task automatic observe(input int code);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse cyc %0d: got %0d expected none", cyc, code);
        end else begin
            e = exp_q.pop_front();
            if (e.code != code || e.cyc != cyc) begin
                errors++;
                $display("FAIL pulse cyc %0d: got code %0d expected code %0d at cyc %0d", cyc, code, e.code, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus0.load_digit)     observe(16 + int'(bus0.op_idx));
        if (bus0.load_op != '0)  observe(32 + int'(bus0.load_op));
        if (bus0.calc_start)     observe(48);
        if (bus0.load_m)         observe(64);
    end

    task automatic apply(input vec_t v, input int row);
        ev_t e;
        @(negedge clk);
        bus0.key_valid = (v.kv != 0);
        bus0.key_code  = 4'(v.kc);
        bus0.calc_done = (v.cd != 0);
        e.cyc = cyc + 1;
        if (v.ld != 0) begin e.code = 16 + v.idx; exp_q.push_back(e); end
        if (v.lo != 0) begin e.code = 32 + v.lo;  exp_q.push_back(e); end
        if (v.cs != 0) begin e.code = 48;         exp_q.push_back(e); end
        if (v.lm != 0) begin e.code = 64;         exp_q.push_back(e); end
        @(posedge clk); #1;
        bus0.key_valid = 1'b0;
        bus0.calc_done = 1'b0;
        check("busy_idx_err", row, int'({bus0.busy, bus0.op_idx, bus0.err}), v.busy * 4 + v.idx * 2 + v.err);
    endtask

    task automatic key1(input int kv, input int kc, input int exp);
        @(negedge clk);
        bus1.key_valid = (kv != 0);
        bus1.key_code  = 4'(kc);
        @(posedge clk); #1;
        bus1.key_valid = 1'b0;
        check("n3_ld_op_start", kc, int'({bus1.load_digit, bus1.load_op, bus1.calc_start}), exp);
    endtask

    task automatic prep_wait();
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 14, 0, 0, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 2, 0, 1, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 14, 0, 0, 2, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
    endtask

    initial begin
        bus0.key_valid = 1'b0; bus0.key_code = 4'h0; bus0.calc_done = 1'b0;
        bus1.key_valid = 1'b0; bus1.key_code = 4'h0; bus1.calc_done = 1'b0;

        // kv kc cd | ld lo cs lm | busy idx err
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 2, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 14, 0, 0, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 3, 0, 1, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 14, 0, 0, 2, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 6, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 5, 1, 0, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 2, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 3, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 4, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 14, 0, 0, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 14, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 10, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 15, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 14, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 7, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 14, 0, 0, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 8, 0, 1, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 14, 0, 0, 2, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 15, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        prep_wait();
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(1, 15, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef OPERAND_SEQ_WATCHDOG_EN
        prep_wait();
        for (int i = 0; i < TIMEOUT - 1; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 3, 1, 0, 0, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 15, 0, 0, 0, 0, 0, 0, 0, 0));
        prep_wait();
        for (int i = 0; i < TIMEOUT - 1; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`endif

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs_n2", 0, int'({bus0.op_idx, bus0.load_digit, bus0.load_op, bus0.calc_start,
                                          bus0.load_m, bus0.busy, bus0.err}), 0);
        check("reset_outputs_n3", 0, int'({bus1.op_idx, bus1.load_digit, bus1.load_op, bus1.calc_start,
                                          bus1.load_m, bus1.busy, bus1.err}), 0);
        rst = 1'b0;

        foreach (tbl[i]) apply(tbl[i], i);

        // reset pulse while waiting for calc_done drops the calculation
        tbl.delete();
        prep_wait();
        foreach (tbl[i]) apply(tbl[i], 100 + i);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_in_wait_outputs", 200, int'({bus0.op_idx, bus0.load_digit, bus0.load_op, bus0.calc_start,
                                               bus0.load_m, bus0.busy, bus0.err}), 0);
        apply(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 201);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 202);

        // three single-digit operands
        key1(1, 7, 16);
        key1(1, 14, 2);
        key1(1, 8, 16);
        key1(1, 14, 4);
        key1(1, 9, 16);
        key1(1, 14, 8);
        key1(0, 0, 1);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", 300, exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
